noise_rnd_bank: RTL and testbench

- Bank of 12 independent 32-bit Galois LFSRs.
- Each clock, produces twelve fresh 12-bit uniform samples, RND1..RND12.
- Feeds the noise summation stage, which sums the twelve samples to approximate Gaussian noise.
- Start/stop control with a warm-up phase, plus a valid flag so downstream knows when samples are usable.

---
 rtl/noise_rnd_bank_if.sv | 40 ++++
 rtl/noise_rnd_bank.sv | 145 ++++++++++++++
 tb/tb_noise_rnd_bank.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/noise_rnd_bank_if.sv
// rtl/noise_rnd_bank_if.sv - control and sample bundle for the noise_rnd_bank LFSR bank
// Purpose: groups start/stop control, the valid flag and the twelve 12-bit samples.
// Signals:
//   GEN_START, GEN_STOP            master -> bank  run control
//   RND_VALID, RND1..RND12         bank -> master  registered samples and valid flag
//   SEED_WR, SEED_SEL, SEED_DATA   master -> bank  seed load, only with NOISE_RND_SEED_LOAD_EN
interface noise_rnd_bank_if;
    logic        GEN_START;
    logic        GEN_STOP;
    logic        RND_VALID;
    logic [11:0] RND1, RND2, RND3, RND4, RND5, RND6;
    logic [11:0] RND7, RND8, RND9, RND10, RND11, RND12;
`ifdef NOISE_RND_SEED_LOAD_EN
    logic        SEED_WR;
    logic [3:0]  SEED_SEL;
    logic [31:0] SEED_DATA;

    modport slave (
        input  GEN_START, GEN_STOP, SEED_WR, SEED_SEL, SEED_DATA,
        output RND_VALID, RND1, RND2, RND3, RND4, RND5, RND6,
               RND7, RND8, RND9, RND10, RND11, RND12
    );
    modport master (
        output GEN_START, GEN_STOP, SEED_WR, SEED_SEL, SEED_DATA,
        input  RND_VALID, RND1, RND2, RND3, RND4, RND5, RND6,
               RND7, RND8, RND9, RND10, RND11, RND12
    );
`else
    modport slave (
        input  GEN_START, GEN_STOP,
        output RND_VALID, RND1, RND2, RND3, RND4, RND5, RND6,
               RND7, RND8, RND9, RND10, RND11, RND12
    );
    modport master (
        output GEN_START, GEN_STOP,
        input  RND_VALID, RND1, RND2, RND3, RND4, RND5, RND6,
               RND7, RND8, RND9, RND10, RND11, RND12
    );
`endif
endinterface

// File: rtl/noise_rnd_bank.sv
// rtl/noise_rnd_bank.sv - bank of twelve 32-bit Galois LFSRs producing 12-bit uniform samples
// Purpose: each active clock every lane advances 12 Galois steps; the low 12 bits of the new
//          state are registered as that lane's sample. IDLE/WARMUP/RUN control with a
//          warm-up of _WARMUP cycles after every start; RND_VALID is high only in RUN.
// Ports:
//   CLK    in   clock, posedge
//   RESET  in   synchronous active-high reset: IDLE, outputs zero, lanes reseeded
//   bus    slave modport of noise_rnd_bank_if (GEN_START/GEN_STOP in, RND_VALID/RND1..12 out)
// Option macro: NOISE_RND_SEED_LOAD_EN adds per-lane seed loading in IDLE via
//   SEED_WR/SEED_SEL/SEED_DATA on the interface.
module noise_rnd_bank #(
    parameter logic [31:0] _SEED_BASE = 32'hACE1_2468,
    parameter logic [31:0] _POLY      = 32'h8020_0003,
    parameter logic [7:0]  _WARMUP    = 8'd16
) (
    input  logic             CLK,
    input  logic             RESET,
    noise_rnd_bank_if.slave  bus
);

    typedef enum logic [1:0] {S_IDLE, S_WARMUP, S_RUN} state_t;

    // Lane numbers are 1-based to match the seed derivation.
    function automatic logic [31:0] param_seed(input int lane);
        logic [31:0] s;
        s = _SEED_BASE ^ (32'(lane) * 32'h9E37_79B9);
        return (s == 32'd0) ? 32'h1 : s;
    endfunction

    function automatic logic [31:0] step12(input logic [31:0] s_in);
        logic [31:0] s;
        s = s_in;
        for (int k = 0; k < 12; k++) begin
            s = s[0] ? ((s >> 1) ^ _POLY) : (s >> 1);
        end
        return s;
    endfunction

    state_t      r_fsm;
    logic [7:0]  r_cnt;
    logic        r_valid;
    logic [31:0] r_state [12];
    logic [11:0] r_rnd   [12];
    logic [31:0] w_seed  [12];
    logic [31:0] w_step  [12];
    logic [31:0] w_next  [12];

`ifdef NOISE_RND_SEED_LOAD_EN
    logic [31:0] r_seed [12];
    logic        w_seed_wr_ok;
    logic [3:0]  w_seed_idx;
    logic [31:0] w_seed_val;

    assign w_seed_wr_ok = bus.SEED_WR && (bus.SEED_SEL >= 4'd1) && (bus.SEED_SEL <= 4'd12);
    assign w_seed_idx   = bus.SEED_SEL - 4'd1;
    assign w_seed_val   = (bus.SEED_DATA == 32'd0) ? 32'h1 : bus.SEED_DATA;

    always_comb begin
        for (int i = 0; i < 12; i++) w_seed[i] = r_seed[i];
    end
`else
    always_comb begin
        for (int i = 0; i < 12; i++) w_seed[i] = param_seed(i + 1);
    end
`endif

    // An all-zero state would lock the lane forever; fall back to the lane seed.
    always_comb begin
        for (int i = 0; i < 12; i++) begin
            w_step[i] = step12(r_state[i]);
            w_next[i] = (w_step[i] == 32'd0) ? w_seed[i] : w_step[i];
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_fsm   <= S_IDLE;
            r_cnt   <= 8'd0;
            r_valid <= 1'b0;
            for (int i = 0; i < 12; i++) begin
                r_state[i] <= param_seed(i + 1);
                r_rnd[i]   <= 12'd0;
`ifdef NOISE_RND_SEED_LOAD_EN
                r_seed[i]  <= param_seed(i + 1);
`endif
            end
        end else begin
            case (r_fsm)
                S_IDLE: begin
                    r_valid <= 1'b0;
                    if (bus.GEN_START && !bus.GEN_STOP) begin
                        r_fsm <= S_WARMUP;
                        r_cnt <= _WARMUP - 8'd1;
                    end
`ifdef NOISE_RND_SEED_LOAD_EN
                    if (w_seed_wr_ok) begin
                        r_state[w_seed_idx] <= w_seed_val;
                        r_seed[w_seed_idx]  <= w_seed_val;
                    end
`endif
                end
                S_WARMUP, S_RUN: begin
                    if (bus.GEN_STOP) begin
                        // Stop takes effect on this edge: no advance, samples hold.
                        r_fsm   <= S_IDLE;
                        r_valid <= 1'b0;
                    end else begin
                        for (int i = 0; i < 12; i++) begin
                            r_state[i] <= w_next[i];
                            r_rnd[i]   <= w_next[i][11:0];
                        end
                        if (r_fsm == S_RUN) begin
                            r_valid <= 1'b1;
                        end else if (r_cnt == 8'd0) begin
                            // Valid rises with the first sample set produced after warm-up.
                            r_fsm   <= S_RUN;
                            r_valid <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt - 8'd1;
                        end
                    end
                end
                default: begin
                    r_fsm   <= S_IDLE;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign bus.RND_VALID = r_valid;
    assign bus.RND1  = r_rnd[0];
    assign bus.RND2  = r_rnd[1];
    assign bus.RND3  = r_rnd[2];
    assign bus.RND4  = r_rnd[3];
    assign bus.RND5  = r_rnd[4];
    assign bus.RND6  = r_rnd[5];
    assign bus.RND7  = r_rnd[6];
    assign bus.RND8  = r_rnd[7];
    assign bus.RND9  = r_rnd[8];
    assign bus.RND10 = r_rnd[9];
    assign bus.RND11 = r_rnd[10];
    assign bus.RND12 = r_rnd[11];

endmodule

// File: tb/tb_noise_rnd_bank.sv
// tb/tb_noise_rnd_bank.sv - self-checking bench for noise_rnd_bank
module tb_noise_rnd_bank;

    localparam logic [31:0] SEED_BASE = 32'hACE1_2468;
    localparam logic [31:0] POLY      = 32'h8020_0003;

    logic CLK = 1'b0;
    logic RESET;
    always #5 CLK = ~CLK;

    noise_rnd_bank_if bus();

    noise_rnd_bank dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    typedef struct {
        logic start;
        logic stop;
        int   n;
        logic valid;
        logic adv;
    } vec_t;

    vec_t        tbl [24];
    int          tbl_n;
    int          errors = 0;
    int          checks = 0;
    logic [31:0] m_st   [12];
    logic [31:0] m_seed [12];
    logic [11:0] m_rnd  [12];
    logic [11:0] act_rnd[12];
    longint      sum_acc = 0;
    int          sum_n = 0;

    assign act_rnd[0]  = bus.RND1;
    assign act_rnd[1]  = bus.RND2;
    assign act_rnd[2]  = bus.RND3;
    assign act_rnd[3]  = bus.RND4;
    assign act_rnd[4]  = bus.RND5;
    assign act_rnd[5]  = bus.RND6;
    assign act_rnd[6]  = bus.RND7;
    assign act_rnd[7]  = bus.RND8;
    assign act_rnd[8]  = bus.RND9;
    assign act_rnd[9]  = bus.RND10;
    assign act_rnd[10] = bus.RND11;
    assign act_rnd[11] = bus.RND12;

    function automatic logic [31:0] spec_seed(input int lane);
        logic [31:0] s;
        s = SEED_BASE ^ (32'(lane) * 32'h9E37_79B9);
        if (s == 32'd0) s = 32'h1;
        return s;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 12; i++) begin
            m_seed[i] = spec_seed(i + 1);
            m_st[i]   = m_seed[i];
            m_rnd[i]  = 12'd0;
        end
    endtask

    task automatic model_adv();
        logic [31:0] s;
        for (int i = 0; i < 12; i++) begin
            s = m_st[i];
            for (int k = 0; k < 12; k++) s = s[0] ? ((s >> 1) ^ POLY) : (s >> 1);
            if (s == 32'd0) s = m_seed[i];
            m_st[i]  = s;
            m_rnd[i] = s[11:0];
        end
    endtask

    task automatic check_cycle(input string tag, input logic exp_valid);
        logic [143:0] a, e;
        int           lane_sum;
        for (int i = 0; i < 12; i++) begin
            a[i*12 +: 12] = act_rnd[i];
            e[i*12 +: 12] = m_rnd[i];
        end
        checks++;
        if (bus.RND_VALID !== exp_valid) begin
            errors++;
            $display("FAIL %s valid: got %b expected %b at %0t", tag, bus.RND_VALID, exp_valid, $time);
        end
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s rnd: got %h expected %h at %0t", tag, a, e, $time);
        end
        if (bus.RND_VALID === 1'b1) begin
            lane_sum = 0;
            for (int i = 0; i < 12; i++) lane_sum += int'(act_rnd[i]);
            sum_acc += lane_sum;
            sum_n++;
        end
    endtask

    task automatic check_states(input string tag);
        for (int i = 0; i < 12; i++) begin
            checks++;
            if (dut.r_state[i] !== m_st[i]) begin
                errors++;
                $display("FAIL %s lane%0d state: got %h expected %h", tag, i + 1, dut.r_state[i], m_st[i]);
            end
        end
    endtask

    task automatic run_seg(input int idx);
        for (int c = 0; c < tbl[idx].n; c++) begin
            bus.GEN_START = tbl[idx].start;
            bus.GEN_STOP  = tbl[idx].stop;
            @(posedge CLK); #1;
            if (tbl[idx].adv) model_adv();
            check_cycle($sformatf("vec%0d", idx), tbl[idx].valid);
        end
        bus.GEN_START = 1'b0;
        bus.GEN_STOP  = 1'b0;
    endtask

    task automatic add(input logic st, input logic sp, input int n, input logic v, input logic ad);
        tbl[tbl_n] = '{start: st, stop: sp, n: n, valid: v, adv: ad};
        tbl_n++;
    endtask

    initial begin
        // First run: start, 16 warm-up advances, valid from cycle 17, stop after 1000 sets
        tbl_n = 0;
        add(1, 0, 1,    0, 0);   // 0: start sampled in IDLE
        add(0, 0, 15,   0, 1);   // 1: warm-up, output discarded
        add(0, 0, 1,    1, 1);   // 2: last warm-up edge -> RUN, first valid set
        add(0, 0, 999,  1, 1);   // 3: run
        add(0, 1, 1,    0, 0);   // 4: stop: valid drops, outputs hold
        add(0, 0, 5,    0, 0);   // 5: idle, frozen
        add(1, 1, 3,    0, 0);   // 6: start+stop together: stays IDLE
        add(1, 0, 1,    0, 0);   // 7: restart
        add(0, 0, 15,   0, 1);   // 8
        add(0, 0, 1,    1, 1);   // 9
        add(0, 0, 9000, 1, 1);   // 10: sequence continues, no reseed
        add(0, 1, 1,    0, 0);   // 11
        add(1, 0, 1,    0, 0);   // 12: start, then stop inside warm-up
        add(0, 0, 5,    0, 1);   // 13
        add(0, 1, 1,    0, 0);   // 14
        add(0, 0, 2,    0, 0);   // 15
        add(1, 0, 1,    0, 0);   // 16: restart repeats the full warm-up
        add(0, 0, 15,   0, 1);   // 17
        add(0, 0, 1,    1, 1);   // 18
        add(0, 0, 50,   1, 1);   // 19

        bus.GEN_START = 1'b0;
        bus.GEN_STOP  = 1'b0;
`ifdef NOISE_RND_SEED_LOAD_EN
        bus.SEED_WR   = 1'b0;
        bus.SEED_SEL  = 4'd0;
        bus.SEED_DATA = 32'd0;
`endif
        RESET = 1'b1;
        model_reset();
        repeat (2) @(posedge CLK);
        #1;
        RESET = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(posedge CLK); #1;
            check_cycle("idle_after_reset", 1'b0);
        end
        checks++;
        if (dut.r_state[0] !== 32'h32D6_5DD1) begin
            errors++;
            $display("FAIL lane1_reset_state: got %h expected %h", dut.r_state[0], 32'h32D6_5DD1);
        end
        check_states("reset_seeds");

        for (int v = 0; v < tbl_n; v++) run_seg(v);

        // Reset in the middle of RUN: outputs clear, lanes reseed, first run reproduces
        RESET = 1'b1;
        @(posedge CLK); #1;
        RESET = 1'b0;
        model_reset();
        check_cycle("reset_in_run", 1'b0);
        check_states("reset_in_run");
        for (int v = 0; v < 4; v++) run_seg(v);
        run_seg(4);

`ifdef NOISE_RND_SEED_LOAD_EN
        RESET = 1'b1;
        @(posedge CLK); #1;
        RESET = 1'b0;
        model_reset();
        bus.SEED_WR = 1'b1; bus.SEED_SEL = 4'd3; bus.SEED_DATA = 32'h0;
        @(posedge CLK); #1;
        m_st[2] = 32'h1; m_seed[2] = 32'h1;
        bus.SEED_SEL = 4'd0; bus.SEED_DATA = 32'hDEAD_BEEF;
        @(posedge CLK); #1;
        bus.SEED_SEL = 4'd13;
        @(posedge CLK); #1;
        bus.SEED_WR = 1'b0;
        checks++;
        if (dut.r_state[2] !== 32'h1) begin
            errors++;
            $display("FAIL seed_zero_lane3: got %h expected %h", dut.r_state[2], 32'h1);
        end
        check_states("seed_load");
        run_seg(0); run_seg(1); run_seg(2);
        bus.SEED_WR = 1'b1; bus.SEED_SEL = 4'd5; bus.SEED_DATA = 32'h1234_5678;
        run_seg(19);
        bus.SEED_WR = 1'b0;
        check_states("seed_write_in_run");
        run_seg(4);
`endif

        checks++;
        if (sum_n == 0 || (sum_acc / sum_n) < 64'sd24170 || (sum_acc / sum_n) > 64'sd24970) begin
            errors++;
            $display("FAIL sum_mean: got %0d over %0d sets expected 24570 +/- 400",
                     (sum_n == 0) ? 0 : (sum_acc / sum_n), sum_n);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
